// File: rtl/case_7_mul_arbiter.sv
// Round-robin arbiter feeding one shared signed multiplier through an operand stage and a result stage.
// Define CASE_7_MUL_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module case_7_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DIN_W   = 10,
    parameter int DOUT_W  = 10,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*DIN_W-1:0] req_din0,
    input  logic [NUM_REQ*DIN_W-1:0] req_din1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DOUT_W-1:0]        rsp_dout,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic                 a_valid_r;
    logic [DIN_W-1:0]     a_din0_r;
    logic [DIN_W-1:0]     a_din1_r;
    logic [ID_W-1:0]      a_id_r;
    logic                 rsp_valid_r;
    logic [DOUT_W-1:0]    rsp_dout_r;
    logic [ID_W-1:0]      rsp_id_r;
`ifndef CASE_7_MUL_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]      ptr_r;
`endif

    logic                 r_adv_s;
    logic                 a_adv_s;
    logic                 a_open_s;
    logic                 win_found_s;
    logic [ID_W-1:0]      win_idx_s;
    logic [ID_W-1:0]      cand_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic                 handshake_s;
    logic [DIN_W-1:0]     sel_din0_s;
    logic [DIN_W-1:0]     sel_din1_s;
    logic [2*DIN_W-1:0]   a_ext_s;
    logic [2*DIN_W-1:0]   b_ext_s;
    logic [DOUT_W-1:0]    prod_s;

    assign r_adv_s  = !rsp_valid_r || rsp_ready;
    assign a_adv_s  = a_valid_r && r_adv_s;
    assign a_open_s = !a_valid_r || r_adv_s;

    // Grant search: first valid requester after the last winner, wrapping around.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
`ifdef CASE_7_MUL_ARB_FIXED_PRIO_EN
        cand_s      = '0;
`else
        cand_s      = (ptr_r == LAST_ID) ? '0 : ptr_r + ID_W'(1);
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found_s && req_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
            cand_s = (cand_s == LAST_ID) ? '0 : cand_s + ID_W'(1);
        end
    end

    // One-hot accept for the winner, suppressed while in reset or while stage A cannot take data.
    always_comb begin
        req_ready_s = '0;
        if (!ap_rst && win_found_s && a_open_s) begin
            req_ready_s[win_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign req_ready   = req_ready_s;
    assign handshake_s = |(req_valid & req_ready_s);

    // Operand mux for the winning requester.
    always_comb begin
        sel_din0_s = '0;
        sel_din1_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx_s == ID_W'(k)) begin
                sel_din0_s = req_din0[k*DIN_W +: DIN_W];
                sel_din1_s = req_din1[k*DIN_W +: DIN_W];
            end else begin
                sel_din0_s = sel_din0_s;
                sel_din1_s = sel_din1_s;
            end
        end
    end

    // Sign-extend to the full product width; the low bits of an unsigned product are then the signed result.
    assign a_ext_s = {{DIN_W{a_din0_r[DIN_W-1]}}, a_din0_r};
    assign b_ext_s = {{DIN_W{a_din1_r[DIN_W-1]}}, a_din1_r};
    assign prod_s  = DOUT_W'(a_ext_s * b_ext_s);

    // Pipeline state: operand stage A, result stage R and the round-robin pointer.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_valid_r   <= 1'b0;
            a_din0_r    <= '0;
            a_din1_r    <= '0;
            a_id_r      <= '0;
            rsp_valid_r <= 1'b0;
            rsp_dout_r  <= '0;
            rsp_id_r    <= '0;
`ifndef CASE_7_MUL_ARB_FIXED_PRIO_EN
            ptr_r       <= LAST_ID;
`endif
        end else begin
            if (a_adv_s) begin
                rsp_valid_r <= 1'b1;
                rsp_dout_r  <= prod_s;
                rsp_id_r    <= a_id_r;
            end else if (rsp_valid_r && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end

            if (handshake_s) begin
                a_valid_r <= 1'b1;
                a_din0_r  <= sel_din0_s;
                a_din1_r  <= sel_din1_s;
                a_id_r    <= win_idx_s;
`ifndef CASE_7_MUL_ARB_FIXED_PRIO_EN
                ptr_r     <= win_idx_s;
`endif
            end else if (a_adv_s) begin
                a_valid_r <= 1'b0;
            end else begin
                a_valid_r <= a_valid_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_dout  = rsp_dout_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = a_valid_r || rsp_valid_r;

endmodule

// File: doc/case_7_mul_arbiter.md
# case_7_mul_arbiter

Round-robin arbiter and two-stage sequencer that shares one signed DIN_W×DIN_W multiplier (truncated DOUT_W-bit product) among NUM_REQ requesters. It sits between the kernel's parallel operand producers and the single shared multiplier instance. It registers the operands and the product, tags each result with the winning requester index, and propagates backpressure from the single result consumer.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DIN_W, 10: signed operand width
- DOUT_W, 10: result width; low DOUT_W bits of the full 2·DIN_W signed product
- ID_W, $clog2(NUM_REQ): requester tag width
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_din0  in  NUM_REQ·DIN_W  operand A; requester i occupies bits [i·DIN_W +: DIN_W]
- req_din1  in  NUM_REQ·DIN_W  operand B; same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_dout  out  DOUT_W  product, two's complement, truncated
- rsp_id  out  ID_W  index of the requester that produced this result
- busy  out  1  high while either pipeline stage holds valid data

## Operation
- Stage A (operand register): a_valid, a_din0, a_din1, a_id.
- Stage R (result register): rsp_valid, rsp_dout, rsp_id.
- The multiplier sits combinationally between A and R: $signed(a_din0)·$signed(a_din1), keeping the low DOUT_W bits.
- r_adv = !rsp_valid | rsp_ready. a_adv = a_valid & r_adv. a_open = !a_valid | r_adv.
- Grant: search req_valid starting at index (ptr+1) mod NUM_REQ and wrap. The first set bit wins. req_ready[win] = a_open. All other req_ready bits are 0.
- req_ready depends combinationally on req_valid. Requesters must not derive req_valid from req_ready.
- Handshake for requester i is req_valid[i] & req_ready[i]. On a handshake:
  - A loads the operands of requester i, sets a_id = i, and sets a_valid = 1.
  - ptr updates to i.
- ptr changes only on a handshake. An idle cycle or a blocked grant leaves ptr unchanged.
- When a_adv: R loads the product and a_id, and rsp_valid = 1. If there is no simultaneous handshake, a_valid clears.
- When rsp_valid & rsp_ready and !a_valid: rsp_valid clears.
- R holds rsp_dout and rsp_id stable while rsp_valid & !rsp_ready.
- A requester must hold req_valid and its operands stable until its handshake. Dropping them earlier is a protocol violation; the behaviour is undefined but the block must not lock up.
- busy = a_valid | rsp_valid.

## Timing
- Reset values:
  - req_ready = 0 during the reset cycle.
  - rsp_valid = 0, rsp_dout = 0, rsp_id = 0.
  - a_valid = 0, busy = 0.
  - ptr = NUM_REQ-1, so requester 0 has first priority.
- Latency: a handshake in cycle T gives rsp_valid = 1 in cycle T+2, provided R is not stalled.
- Throughput: one request per cycle when rsp_ready is held high.
- Full pipeline (a_valid & rsp_valid & !rsp_ready): all req_ready = 0, and nothing moves.
- Drain and accept in the same cycle: R takes A, and A takes the new request. No bubble.
- ap_rst asserted mid-operation: both stages are discarded, results in flight are lost, and ptr returns to NUM_REQ-1 at the next edge.

## Configuration
- Macro: CASE_7_MUL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins, and ptr is not implemented.
- Undefined (default): round-robin as described above.
- Handshake, latency and datapath are identical in both modes.

## Test plan
- Single request: requester 2 sends din0 = -3, din1 = 5 in cycle 1. Required: rsp_valid in cycle 3, rsp_dout = 10'h3F1, rsp_id = 2.
- Four requesters assert continuously with rsp_ready = 1. Required:
  - rsp_id sequence 0,1,2,3,0,1,… with one result per cycle;
  - operands -512×-512 give rsp_dout = 10'h000;
  - operands 511×511 give rsp_dout = 10'h001.
- Backpressure: rsp_ready = 0 for 5 cycles while requests are pending. Required:
  - rsp_dout and rsp_id stay stable;
  - exactly one further request is accepted into A, then all req_ready = 0;
  - after rsp_ready rises, results come out in order with no loss or duplication.
- Reset mid-operation: assert ap_rst while both stages are valid. Required: rsp_valid = 0 and busy = 0 next cycle; the first grant after reset goes to requester 0.
- Fairness hold: requester 1 is granted. Then requesters 1 and 3 are valid while the pipeline is stalled for 3 cycles. Required: requester 3 wins after the stall, because ptr did not advance during it.
- Build with CASE_7_MUL_ARB_FIXED_PRIO_EN and requesters 0 and 3 both asserting continuously. Required: every result has rsp_id = 0 until requester 0 drops req_valid.
